branch_redirect_unit: RTL

Execute-stage block that consumes the word-aligned branch offset produced by the shift-left-by-2 stage. It adds that offset to the branch PC and registers the result as a redirect request to the fetch stage. The request is held under a valid/ready handshake until fetch accepts it, stalling execute when a second taken branch arrives while a redirect is still pending. It also keeps a saturating count of issued redirects for performance monitoring.

---
 rtl/branch_redirect_unit.sv | 59 +++++
 1 files changed

// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: registers branch target redirects to fetch with valid/ready hold; MISALIGN_TRAP_EN traps misaligned targets
module branch_redirect_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_offset_sl2,
  input  logic             if_ready,
  output logic             ex_stall,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_target,
  output logic             flush,
  output logic [CNT_W-1:0] redir_count
`ifdef MISALIGN_TRAP_EN
  , output logic           misalign_err
`endif
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state;
  logic [XLEN-1:0] sum, tgt;
  logic take, cap, acc, mis;
  assign sum = ex_pc + ex_offset_sl2;
  assign take = ex_valid & ex_taken;
  assign ex_stall = rst_n & (state == PEND) & ~if_ready & take;
  assign acc = (state == PEND) & if_ready;
  assign redir_valid = state == PEND;
`ifdef MISALIGN_TRAP_EN
  assign tgt = sum;
  assign mis = take & ~ex_stall & |sum[1:0];
`else
  assign tgt = sum & ~{{(XLEN-2){1'b0}}, 2'b11};
  assign mis = 1'b0;
`endif
  assign cap = take & ~ex_stall & ~mis;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      redir_target <= '0;
      flush <= 1'b0;
      redir_count <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      flush <= cap;
      if (cap) state <= PEND;
      else if (acc) state <= IDLE;
      if (cap || mis) redir_target <= tgt;
      if (cap && !(&redir_count)) redir_count <= redir_count + 1'b1;
`ifdef MISALIGN_TRAP_EN
      misalign_err <= mis;
`endif
    end
  end
endmodule
